// File: rtl/lieat_ifu_ibuf_pkg.sv
// Shared IFU constants for the instruction buffer: fetch packet geometry and the core XLEN default.
`ifndef XLEN
`define XLEN 32
`endif

package lieat_ifu_ibuf_pkg;

    localparam int unsigned IBUF_SLOT_W = 32;
    localparam int unsigned IBUF_PKT_W  = 64;
    localparam int unsigned IBUF_SLOTS  = 2;

endpackage

// File: rtl/lieat_ifu_ibuf.sv
// Instruction buffer: splits 64-bit icache packets into 32-bit slots, queues them in a
// DEPTH-entry circular buffer and issues one {pc,inst} per cycle to decode.
`ifndef XLEN
`define XLEN 32
`endif

module lieat_ifu_ibuf
    import lieat_ifu_ibuf_pkg::*;
#(
    parameter int unsigned XLEN   = `XLEN,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned BYPASS = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush_req,
    input  logic                     pkt_valid,
    output logic                     pkt_ready,
    input  logic [XLEN-1:0]          pkt_pc,
    input  logic [IBUF_PKT_W-1:0]    pkt_data,
    output logic                     if_o_valid,
    input  logic                     if_o_ready,
    output logic [XLEN-1:0]          if_o_pc,
    output logic [IBUF_SLOT_W-1:0]   if_o_inst,
    output logic [$clog2(DEPTH):0]   ibuf_count
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;
    localparam logic [PW-1:0] ACCEPT_LIM = PW'(DEPTH - IBUF_SLOTS);

    logic [XLEN-1:0]        mem_pc   [DEPTH];
    logic [IBUF_SLOT_W-1:0] mem_inst [DEPTH];

    logic [PW-1:0] rd_ptr, wr_ptr, count;
    logic [IW-1:0] rd_idx, wr_idx, wr1_idx;

    logic [XLEN-1:0]        base_pc, slot1_pc, first_pc, w0_pc;
    logic [IBUF_SLOT_W-1:0] slot0_inst, slot1_inst, first_inst, w0_inst;
    logic                   empty, accept, bypass_on, deq, skip, buf_deq;
    logic [1:0]             n_enq;

    // Occupancy is the wrap-bit pointer difference, so it always equals the registered enq/deq history.
    assign count      = wr_ptr - rd_ptr;
    assign ibuf_count = count;
    assign rd_idx     = rd_ptr[IW-1:0];
    assign wr_idx     = wr_ptr[IW-1:0];
    assign wr1_idx    = wr_idx + IW'(1);

    assign pkt_ready  = !flush_req && (count <= ACCEPT_LIM);

    always_comb begin
        base_pc    = pkt_pc & ~XLEN'(7);
        slot1_pc   = base_pc | XLEN'(4);
        slot0_inst = pkt_data[IBUF_SLOT_W-1:0];
        slot1_inst = pkt_data[IBUF_PKT_W-1:IBUF_SLOT_W];
        first_pc   = pkt_pc[2] ? slot1_pc   : base_pc;
        first_inst = pkt_pc[2] ? slot1_inst : slot0_inst;

        empty      = (count == '0);
        accept     = pkt_valid && pkt_ready;
        bypass_on  = (BYPASS != 0) && empty;

        if (bypass_on) begin
            if_o_valid = accept;
            if_o_pc    = first_pc;
            if_o_inst  = first_inst;
        end else begin
            if_o_valid = !empty && !flush_req;
            if_o_pc    = mem_pc[rd_idx];
            if_o_inst  = mem_inst[rd_idx];
        end

        deq     = if_o_valid && if_o_ready;
        skip    = bypass_on && deq;
        buf_deq = deq && !bypass_on;

        // A bypassed first slot is never written; only the slot behind it (if any) is queued.
        n_enq = 2'd0;
        if (accept) begin
            if (pkt_pc[2]) n_enq = skip ? 2'd0 : 2'd1;
            else           n_enq = skip ? 2'd1 : 2'd2;
        end
        w0_pc   = (pkt_pc[2] || skip) ? slot1_pc   : base_pc;
        w0_inst = (pkt_pc[2] || skip) ? slot1_inst : slot0_inst;
    end

    always_ff @(posedge clock) begin
        if (reset || flush_req) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_enq);
            rd_ptr <= rd_ptr + PW'(buf_deq);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (n_enq != 2'd0) begin
                mem_pc[wr_idx]   <= w0_pc;
                mem_inst[wr_idx] <= w0_inst;
            end
            if (n_enq == 2'd2) begin
                mem_pc[wr1_idx]   <= slot1_pc;
                mem_inst[wr1_idx] <= slot1_inst;
            end
        end
    end

endmodule

// File: tb/tb_lieat_ifu_ibuf.sv
// Directed scoreboard bench for lieat_ifu_ibuf: a DEPTH=4 buffered instance and a
// DEPTH=4 BYPASS=1 instance driven by one linear stimulus sequence.
module tb_lieat_ifu_ibuf;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, flush_req, pkt_valid, pkt_ready, if_o_valid, if_o_ready;
    logic [31:0] pkt_pc, if_o_pc, if_o_inst;
    logic [63:0] pkt_data;
    logic [2:0]  ibuf_count;

    logic        b_flush, b_pkt_valid, b_pkt_ready, b_valid, b_ready;
    logic [31:0] b_pkt_pc, b_pc, b_inst;
    logic [63:0] b_pkt_data;
    logic [2:0]  b_count;

    lieat_ifu_ibuf #(.XLEN(32), .DEPTH(4), .BYPASS(0)) u_dut (
        .clock(clock), .reset(reset), .flush_req(flush_req),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_pc(pkt_pc), .pkt_data(pkt_data),
        .if_o_valid(if_o_valid), .if_o_ready(if_o_ready), .if_o_pc(if_o_pc),
        .if_o_inst(if_o_inst), .ibuf_count(ibuf_count)
    );

    lieat_ifu_ibuf #(.XLEN(32), .DEPTH(4), .BYPASS(1)) u_byp (
        .clock(clock), .reset(reset), .flush_req(b_flush),
        .pkt_valid(b_pkt_valid), .pkt_ready(b_pkt_ready), .pkt_pc(b_pkt_pc), .pkt_data(b_pkt_data),
        .if_o_valid(b_valid), .if_o_ready(b_ready), .if_o_pc(b_pc),
        .if_o_inst(b_inst), .ibuf_count(b_count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a packet on the buffered instance and record the slots it must eventually issue.
    task automatic push_pkt(input logic [31:0] pc, input logic [63:0] data);
        exp_t e;
        pkt_valid = 1'b1;
        pkt_pc    = pc;
        pkt_data  = data;
        if (!pc[2]) begin
            e.pc = pc & ~32'h7;           e.inst = data[31:0];  sb.push_back(e);
            e.pc = (pc & ~32'h7) | 32'h4; e.inst = data[63:32]; sb.push_back(e);
        end else begin
            e.pc = pc & ~32'h3;           e.inst = data[63:32]; sb.push_back(e);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clock);
        if (if_o_valid === 1'b1 && if_o_ready === 1'b1) begin
            n_vec++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_pop: observed pc %0h with empty scoreboard", if_o_pc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("pop_pc_inst", {if_o_pc, if_o_inst}, {e.pc, e.inst});
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush_req = 1'b0; pkt_valid = 1'b0; pkt_pc = '0; pkt_data = '0; if_o_ready = 1'b0;
        b_flush = 1'b0; b_pkt_valid = 1'b0; b_pkt_pc = '0; b_pkt_data = '0; b_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_count", 64'(ibuf_count), 64'd0);
        check("rst_valid", 64'(if_o_valid), 64'd0);
        check("rst_ready", 64'(pkt_ready), 64'd1);
        check("rst_b_count", 64'(b_count), 64'd0);

        // aligned packet, two slots issued in order
        if_o_ready = 1'b1;
        push_pkt(32'h8000_0000, 64'h00500093_00100013);
        tick(); pkt_valid = 1'b0; #1;
        check("t1_count2", 64'(ibuf_count), 64'd2);
        tick();
        check("t1_count1", 64'(ibuf_count), 64'd1);
        tick();
        check("t1_count0", 64'(ibuf_count), 64'd0);
        check("t1_drained", 64'(sb.size()), 64'd0);

        // pc[2]=1: only slot1 is taken
        push_pkt(32'h8000_0004, 64'h00500093_00100013);
        tick(); pkt_valid = 1'b0; #1;
        check("t2_count1", 64'(ibuf_count), 64'd1);
        tick();
        check("t2_count0", 64'(ibuf_count), 64'd0);
        check("t2_drained", 64'(sb.size()), 64'd0);

        // fill to DEPTH with consumer stalled
        if_o_ready = 1'b0;
        push_pkt(32'h8000_0010, 64'h11111111_22222222);
        tick(); #1;
        check("t3_count2", 64'(ibuf_count), 64'd2);
        check("t3_ready2", 64'(pkt_ready), 64'd1);
        push_pkt(32'h8000_0018, 64'h33333333_44444444);
        tick(); pkt_valid = 1'b0; #1;
        check("t3_count4", 64'(ibuf_count), 64'd4);
        check("t3_ready4", 64'(pkt_ready), 64'd0);
        if_o_ready = 1'b1; tick(); if_o_ready = 1'b0; #1;
        check("t3_count3", 64'(ibuf_count), 64'd3);
        check("t3_ready3", 64'(pkt_ready), 64'd0);
        if_o_ready = 1'b1; tick(); if_o_ready = 1'b0; #1;
        check("t3_count2b", 64'(ibuf_count), 64'd2);
        check("t3_ready2b", 64'(pkt_ready), 64'd1);
        push_pkt(32'h8000_002C, 64'h55555555_66666666);
        tick(); pkt_valid = 1'b0; #1;
        check("t3_count3b", 64'(ibuf_count), 64'd3);

        // flush with a packet offered: nothing taken, buffer emptied
        flush_req = 1'b1; pkt_valid = 1'b1; pkt_pc = 32'h8000_0030; pkt_data = 64'h77777777_88888888;
        #1;
        check("t4_flush_valid", 64'(if_o_valid), 64'd0);
        check("t4_flush_ready", 64'(pkt_ready), 64'd0);
        tick();
        flush_req = 1'b0; pkt_valid = 1'b0;
        sb.delete();
        #1;
        check("t4_count0", 64'(ibuf_count), 64'd0);
        check("t4_ready", 64'(pkt_ready), 64'd1);
        check("t4_valid", 64'(if_o_valid), 64'd0);

        // move write index to 3, then straddle the array end
        if_o_ready = 1'b1;
        push_pkt(32'h8000_0100, 64'hA0000001_A0000000);
        tick();
        push_pkt(32'h8000_010C, 64'hA0000003_A0000002);
        tick(); pkt_valid = 1'b0;
        for (int i = 0; i < 6 && ibuf_count != 3'd0; i++) tick();
        check("t5_pre_count", 64'(ibuf_count), 64'd0);
        check("t5_pre_drained", 64'(sb.size()), 64'd0);
        if_o_ready = 1'b0;
        push_pkt(32'h8000_0200, 64'hB0000001_B0000000);
        tick();
        push_pkt(32'h8000_0300, 64'hC0000001_C0000000);
        tick(); pkt_valid = 1'b0; #1;
        check("t5_count4", 64'(ibuf_count), 64'd4);
        if_o_ready = 1'b1;
        for (int i = 0; i < 8 && ibuf_count != 3'd0; i++) tick();
        check("t5_count0", 64'(ibuf_count), 64'd0);
        check("t5_drained", 64'(sb.size()), 64'd0);

        // reset while occupied
        if_o_ready = 1'b0;
        push_pkt(32'h8000_0400, 64'hD0000001_D0000000);
        tick(); pkt_valid = 1'b0; #1;
        check("t7_count2", 64'(ibuf_count), 64'd2);
        reset = 1'b1; tick(); reset = 1'b0;
        sb.delete();
        #1;
        check("t7_count0", 64'(ibuf_count), 64'd0);
        check("t7_valid", 64'(if_o_valid), 64'd0);
        check("t7_ready", 64'(pkt_ready), 64'd1);

        // BYPASS=1, empty, consumer ready: first slot issued same cycle
        b_ready = 1'b1; b_pkt_valid = 1'b1; b_pkt_pc = 32'h8000_0000; b_pkt_data = 64'h00500093_00100013;
        #1;
        check("t6_valid", 64'(b_valid), 64'd1);
        check("t6_pc_inst", {b_pc, b_inst}, {32'h8000_0000, 32'h00100013});
        tick(); b_pkt_valid = 1'b0; #1;
        check("t6_count1", 64'(b_count), 64'd1);
        check("t6_head", {b_pc, b_inst}, {32'h8000_0004, 32'h00500093});
        tick();
        check("t6_count0", 64'(b_count), 64'd0);

        // BYPASS=1, consumer stalled: both slots are written
        b_ready = 1'b0; b_pkt_valid = 1'b1; b_pkt_pc = 32'h8000_0040; b_pkt_data = 64'hE0000001_E0000000;
        #1;
        check("t6b_valid", 64'(b_valid), 64'd1);
        check("t6b_pc", 64'(b_pc), 64'h8000_0040);
        tick(); b_pkt_valid = 1'b0; #1;
        check("t6b_count2", 64'(b_count), 64'd2);
        check("t6b_head", {b_pc, b_inst}, {32'h8000_0040, 32'hE0000000});
        b_ready = 1'b1; tick(); #1;
        check("t6b_next", {b_pc, b_inst}, {32'h8000_0044, 32'hE0000001});
        tick();
        check("t6b_count0", 64'(b_count), 64'd0);

        // BYPASS=1, unaligned packet consumed entirely by bypass
        b_pkt_valid = 1'b1; b_pkt_pc = 32'h8000_0084; b_pkt_data = 64'hF0000001_F0000000;
        #1;
        check("t6c_pc_inst", {b_pc, b_inst}, {32'h8000_0084, 32'hF0000001});
        tick(); b_pkt_valid = 1'b0; #1;
        check("t6c_count0", 64'(b_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
